// File: rtl/uart_tx_feeder.sv
// TX feeder for UART1_Simple: queues data/BREAK words in a FIFO and paces them
// into the UART strobe port, expanding timed BREAK commands into on/off pairs.
module uart_tx_feeder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GUARD      = 2,
  parameter int BRK_UNIT   = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_stb,
  input  logic [9:0]            wr_data,
  input  logic                  clr,
  output logic                  wr_full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  idle,
  input  logic                  uart_empty,
  output logic                  uart_stb,
  output logic [9:0]            uart_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int GW    = $clog2(GUARD + 2);
  localparam int BW    = $clog2(512 * BRK_UNIT + 1);
  localparam logic [GW-1:0] GUARD_V    = GW'(GUARD);
  localparam logic [31:0]   BRK_UNIT_U = 32'(BRK_UNIT);

  typedef enum logic {S_IDLE, S_BRK} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [9:0]          mem_q [DEPTH];
  logic                overflow_q, overflow_d;
  logic [GW-1:0]       guard_q, guard_d;
  logic [BW-1:0]       brk_q, brk_d;
  logic                stb_q, stb_d;
  logic [9:0]          data_q, data_d;
  logic                idle_q, idle_d;

  logic                full, empty, push, pop;
  logic                issue_ok, fifo_avail, brk_zero;
  logic [9:0]          head;
  logic [BW-1:0]       brk_len;
  logic [PW-1:0]       level_d;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign full       = level[DEPTH_LOG2];
  assign empty      = (level == '0);
  assign head       = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign issue_ok   = uart_empty & (guard_q == '0);
  assign fifo_avail = ~empty & issue_ok & ~clr;
  assign brk_zero   = (brk_q == '0);
  // Counter starts one below the length so the off strobe lands exactly
  // (n+1)*BRK_UNIT cycles after the on strobe.
  assign brk_len    = BW'((32'(head[8:0]) + 32'd1) * BRK_UNIT_U) - BW'(1);

  // Full is judged on the pre-pop occupancy; clr swallows a same-cycle write.
  assign push       = wr_stb & ~full & ~clr;

  always_comb begin : fifo_next
    wr_ptr_d   = clr ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d   = clr ? '0 : rd_ptr_q + PW'(pop);
    overflow_d = clr ? 1'b0 : (overflow_q | (wr_stb & full));
    level_d    = wr_ptr_d - rd_ptr_d;
  end

  always_comb begin : next_state
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fifo_avail && head[9]) state_d = S_BRK;
      S_BRK:   if (brk_zero && issue_ok)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs
    pop    = 1'b0;
    stb_d  = 1'b0;
    data_d = data_q;
    brk_d  = brk_q;
    case (state_q)
      S_IDLE: begin
        if (fifo_avail) begin
          pop   = 1'b1;
          stb_d = 1'b1;
          if (head[9]) begin
            data_d = 10'h201;
            brk_d  = brk_len;
          end else begin
            data_d = {1'b0, head[8:0]};
          end
        end
      end
      S_BRK: begin
        if (brk_zero) begin
          if (issue_ok) begin
            stb_d  = 1'b1;
            data_d = 10'h200;
          end
        end else if (clr) begin
          brk_d = '0;
        end else begin
          brk_d = brk_q - BW'(1);
        end
      end
      default: ;
    endcase
    guard_d = stb_d ? GUARD_V : ((guard_q != '0) ? guard_q - GW'(1) : '0);
    idle_d  = (level_d == '0) & (state_d == S_IDLE) & (guard_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      guard_q    <= '0;
      brk_q      <= '0;
      stb_q      <= 1'b0;
      data_q     <= '0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      guard_q    <= guard_d;
      brk_q      <= brk_d;
      stb_q      <= stb_d;
      data_q     <= data_d;
      idle_q     <= idle_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
  end

  assign wr_full   = full;
  assign overflow  = overflow_q;
  assign idle      = idle_q;
  assign uart_stb  = stb_q;
  assign uart_data = data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed scenarios plus random traffic,
// all checked against a queue-based transaction model with timing rules.
module tb_uart_tx_feeder;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int GUARD      = 2;
  localparam int BRK_UNIT   = 256;

  logic       clk = 1'b0;
  logic       rst_n, wr_stb, clr, uart_empty;
  logic [9:0] wr_data;
  logic       wr_full, overflow, idle, uart_stb;
  logic [4:0] level;
  logic [9:0] uart_data;

  uart_tx_feeder #(.DEPTH_LOG2(DEPTH_LOG2), .GUARD(GUARD), .BRK_UNIT(BRK_UNIT)) dut (
    .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .wr_data(wr_data), .clr(clr),
    .wr_full(wr_full), .level(level), .overflow(overflow), .idle(idle),
    .uart_empty(uart_empty), .uart_stb(uart_stb), .uart_data(uart_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Inputs as seen by each rising edge
  int         cyc = 0;
  logic       e_wr, e_clr, e_ue, e_rst;
  logic [9:0] e_data;

  always @(posedge clk) begin
    cyc    = cyc + 1;
    e_wr   = wr_stb;
    e_clr  = clr;
    e_ue   = uart_empty;
    e_data = wr_data;
    e_rst  = !rst_n;
  end

  // Transaction model: queued words, pending BREAK-off, last strobe time.
  logic [9:0] fq[$];
  bit         pending_off = 0;
  int         off_ready   = 0;
  int         last_stb    = -1000;
  logic [9:0] last_data   = '0;
  bit         m_ovf       = 0;
  bit         full_before, ready, exp_stb;
  logic [9:0] w;

  always @(negedge clk) begin
    if (e_rst || !rst_n) begin
      fq.delete();
      pending_off = 0;
      last_stb    = -1000;
      last_data   = '0;
      m_ovf       = 0;
    end else begin
      full_before = (fq.size() == DEPTH);
      ready       = e_ue && (cyc - last_stb > GUARD);
      if (pending_off) exp_stb = ready && (cyc >= off_ready);
      else             exp_stb = ready && (fq.size() > 0) && !e_clr;
      check("stb", uart_stb, exp_stb);
      if (exp_stb) begin
        last_stb = cyc;
        if (pending_off) begin
          last_data   = 10'h200;
          pending_off = 0;
        end else begin
          w = fq.pop_front();
          if (w[9]) begin
            last_data   = 10'h201;
            pending_off = 1;
            off_ready   = cyc + (int'(w[8:0]) + 1) * BRK_UNIT;
          end else begin
            last_data = {1'b0, w[8:0]};
          end
        end
      end
      if (e_clr) begin
        fq.delete();
        m_ovf = 0;
        if (pending_off && off_ready > cyc + 1) off_ready = cyc + 1;
      end else if (e_wr) begin
        if (full_before) m_ovf = 1;
        else fq.push_back(e_data);
      end
      check("level", level, fq.size());
      check("wr_full", wr_full, fq.size() == DEPTH);
      check("overflow", overflow, m_ovf);
      check("uart_data", uart_data, last_data);
      check("idle", idle, (fq.size() == 0) && !pending_off && (cyc - last_stb >= GUARD));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic quiet(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      tick(1);
      if (uart_stb) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic wait_stb(input string tag, input int bound, output int at, output logic [9:0] d);
    at = -1;
    d  = 'x;
    for (int i = 0; i < bound; i++) begin
      tick(1);
      if (uart_stb) begin
        at = cyc;
        d  = uart_data;
        break;
      end
    end
    if (at < 0) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int i = 0;
    while (idle !== 1'b1 && i < bound) begin
      tick(1);
      i++;
    end
    check(tag, idle, 1);
  endtask

  int         n0, t_on, at;
  logic [9:0] d;

  initial begin
    rst_n = 0; wr_stb = 0; clr = 0; uart_empty = 0; wr_data = '0;
    tick(3);
    check("rst_stb", uart_stb, 0);
    check("rst_data", uart_data, 0);
    check("rst_level", level, 0);
    check("rst_full", wr_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_idle", idle, 1);
    rst_n = 1;
    uart_empty = 1;
    tick(2);

    // Back-to-back data words: strobes at N+1, N+4, N+7
    n0 = cyc + 1;
    for (int i = 0; i < 11; i++) begin
      wr_stb = (i < 3);
      case (i)
        0: wr_data = 10'h05A;
        1: wr_data = 10'h0A5;
        2: wr_data = 10'h1FF;
        default: wr_data = '0;
      endcase
      tick(1);
      check("b2b_stb", uart_stb, (i == 1) || (i == 4) || (i == 7));
      if (i == 1) check("b2b_d0", uart_data, 10'h05A);
      if (i == 4) check("b2b_d1", uart_data, 10'h0A5);
      if (i == 7) check("b2b_d2", uart_data, 10'h1FF);
    end
    check("b2b_cyc", cyc, n0 + 10);
    check("b2b_idle", idle, 1);

    // Flow control on uart_empty
    wait_idle("fc_pre_idle", 100);
    uart_empty = 0;
    wr_stb = 1; wr_data = 10'h033;
    tick(1);
    wr_stb = 0;
    quiet("fc_hold", 50);
    uart_empty = 1;
    tick(1);
    check("fc_stb", uart_stb, 1);
    check("fc_data", uart_data, 10'h033);

    // Overflow: 17 writes into 16 entries, then clear
    wait_idle("ovf_pre_idle", 100);
    uart_empty = 0;
    for (int i = 0; i < 17; i++) begin
      wr_stb = 1; wr_data = {1'b0, 9'(i + 1)};
      tick(1);
    end
    wr_stb = 0;
    check("ovf_level", level, 16);
    check("ovf_full", wr_full, 1);
    check("ovf_flag", overflow, 1);
    clr = 1;
    tick(1);
    clr = 0;
    check("clr_level", level, 0);
    check("clr_ovf", overflow, 0);
    check("clr_full", wr_full, 0);
    uart_empty = 1;
    quiet("clr_silent", 20);

    // BREAK of 4 units followed by a data word
    wait_idle("brk_pre_idle", 100);
    wr_stb = 1; wr_data = 10'h203;
    tick(1);
    wr_data = 10'h011;
    tick(1);
    wr_stb = 0;
    t_on = cyc;
    check("brk_on_stb", uart_stb, 1);
    check("brk_on_data", uart_data, 10'h201);
    wait_stb("brk_off", 1100, at, d);
    check("brk_off_time", at - t_on, 1024);
    check("brk_off_data", d, 10'h200);
    wait_stb("brk_next", 10, at, d);
    check("brk_next_time", at - t_on, 1027);
    check("brk_next_data", d, 10'h011);

    // Flush during a long BREAK
    wait_idle("fl_pre_idle", 100);
    wr_stb = 1; wr_data = 10'h2FF;
    tick(1);
    wr_data = 10'h011;
    tick(1);
    t_on = cyc;
    check("fl_on_stb", uart_stb, 1);
    check("fl_on_data", uart_data, 10'h201);
    wr_data = 10'h022;
    tick(1);
    wr_data = 10'h044;
    tick(1);
    wr_stb = 0;
    tick(t_on + 9 - cyc);
    clr = 1;
    tick(1);
    clr = 0;
    wait_stb("fl_off", 10, at, d);
    check("fl_off_lat", (at > t_on + 10) && (at - t_on - 10 <= GUARD + 1), 1);
    check("fl_off_data", d, 10'h200);
    quiet("fl_silent", 30);
    check("fl_idle", idle, 1);
    check("fl_level", level, 0);

    // Reset while a BREAK is active
    wr_stb = 1; wr_data = 10'h2FF;
    tick(1);
    wr_data = 10'h077;
    tick(1);
    wr_stb = 0;
    check("rb_on_stb", uart_stb, 1);
    rst_n = 0;
    #1;
    check("rb_stb", uart_stb, 0);
    check("rb_level", level, 0);
    check("rb_ovf", overflow, 0);
    check("rb_idle", idle, 1);
    tick(2);
    rst_n = 1;
    quiet("rb_silent", 20);
    check("rb_idle_after", idle, 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      uart_empty = ($urandom_range(0, 9) < 7);
      clr        = ($urandom_range(0, 199) == 0);
      wr_stb     = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 9) == 0) wr_data = {1'b1, 9'($urandom_range(0, 2))};
      else                           wr_data = {1'b0, 9'($urandom)};
      tick(1);
    end
    wr_stb = 0; clr = 0; uart_empty = 1;
    tick(1);
    wait_idle("drain_idle", 20000);
    check("drain_level", level, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
